data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Word-addressed 19-bit data memory with its own bus controller. Sits directly downstream of the cpu memory port (address, mem_read, mem_write, data bus).
- Accepts one read or write per request and inserts a programmable number of wait states.
- Returns a one-cycle mem_ready pulse and drives read data plus a bus drive-enable; the top level builds the tristate data_bus from wr_data/rd_data/data_oe.

Parameters:
- DATA_W, 19, word width; matches the cpu data bus.
- ADDR_W, 19, width of the cpu address port.
- DEPTH, 256, number of words implemented; valid addresses 0..DEPTH-1.
- WAIT_STATES, 2, extra cycles between accept and array access; range 0..15.
- INIT_FILE, "", if non-empty, loaded into the array with $readmemh at time 0.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- address  input  ADDR_W  word address from the cpu.
- mem_read  input  1  read request, held until mem_ready.
- mem_write  input  1  write request, held until mem_ready.
- wr_data  input  DATA_W  write data from the cpu bus; sampled at accept.
- rd_data  output  DATA_W  read data; valid only while mem_ready=1 for a read.
- data_oe  output  1  high only during a read response; top level drives data_bus from rd_data.
- mem_ready  output  1  one-cycle completion pulse.
- bus_err  output  1  one-cycle pulse with mem_ready on a rejected request.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: already decided — one clock (clk), reset rst is synchronous and active-high. On rst, state=IDLE and wait counter=0. All outputs are 0 at reset: rd_data, data_oe, mem_ready, bus_err, busy. The memory array is not cleared.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: samples mem_read/mem_write every edge. When either is high, it latches address, wr_data and the op, then:
  - goes to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0;
  - otherwise goes to ACCESS.
- WAIT: decrements the counter; goes to ACCESS when counter=0.
- ACCESS: one cycle. A valid write updates the array at the exiting edge. A valid read loads rd_data from the array at the exiting edge. Next state is RESP.
- RESP: one cycle. mem_ready=1; data_oe=1 only for a valid read; bus_err as classified at accept. Returns to IDLE.
- Latency: if accept occurs at edge E0, mem_ready is high during the cycle after edge E0+WAIT_STATES+1. Back-to-back requests are spaced WAIT_STATES+3 cycles apart.
- Master rule: deassert the request by the edge ending RESP. A request still high in IDLE is treated as a new request (sustained requests are not merged).
- Request inputs are ignored outside IDLE. Changes to address or wr_data after accept have no effect.
- Error classes, decided at accept:
  - mem_read and mem_write both high;
  - latched address >= DEPTH.
  
  In either case there is no array access, but the full latency is still spent. RESP shows mem_ready=1, bus_err=1, data_oe=0, rd_data=0.
- rd_data holds its last value outside RESP but is defined only in RESP. The array is DEPTH words, indexed by the low clog2(DEPTH) address bits after the range check.
- Reset mid-operation (WAIT/ACCESS/RESP): the transaction is dropped, with no pulse and no array write if rst is high at the ACCESS exit edge. The next cycle is IDLE.

Optional Feature:
- Macro DATA_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from wr_data on write.
  - A read recomputes parity. A mismatch makes RESP assert bus_err=1, with mem_ready=1, data_oe=1, and rd_data carrying the stored (corrupt) word.
  - The parity array is not reset.
- Undefined: no parity storage or logic; bus_err comes only from the error classes above.

Test Plan:
- Use WAIT_STATES=2. Write 19'd99 to address 5, then read address 5 → mem_ready exactly 3 cycles after each accept edge; read returns rd_data=99 with data_oe=1; bus_err=0 throughout.
- Use WAIT_STATES=0. Write 19'h7FFFF then 19'd42 to addresses 0 and 255, then read both → 42 at 255 and 7FFFF at 0; ready 1 cycle after accept; requests spaced 3 cycles apart.
- Read address 256 (DEPTH=256), then mem_read and mem_write together at address 3 → both pulse mem_ready with bus_err=1 and data_oe=0; address 3 keeps its prior value.
- Change address and wr_data to 7/123 during WAIT of a write to address 4 (data 11) → address 4 = 11 and address 7 is unchanged; mem_read pulsed while busy is ignored.
- Assert rst for one cycle while in WAIT of a write of 77 to address 9 → no mem_ready, address 9 unchanged, busy=0 next cycle; the next read completes normally.
- With DATA_MEM_PARITY_EN: write 19'd6 to address 2, flip array bit 0 hierarchically, read address 2 → bus_err=1, mem_ready=1, rd_data=7.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with request/ready bus controller and programmable wait states.
// Optional even-parity storage and checking is enabled with the DATA_MEM_PARITY_EN macro.
module data_mem_ctrl #(
  parameter int DATA_W      = 19,
  parameter int ADDR_W      = 19,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              data_oe,
  output logic              mem_ready,
  output logic              bus_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              rd_op_q, rd_op_d;
  logic              wr_op_q, wr_op_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_q;
  logic              perr_q;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rd_op_d = rd_op_q;
    wr_op_d = wr_op_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = address[IDX_W-1:0];
          wdat_d  = wr_data;
          rd_op_d = mem_read;
          wr_op_d = mem_write;
          // Errors are classified once here so the rest of the transaction only follows err_q.
          err_d   = (mem_read && mem_write) || (address >= ADDR_W'(DEPTH));
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control and output-visible registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_ACCESS) begin
        if (err_q)        rd_q <= '0;
        else if (rd_op_q) rd_q <= mem[addr_q];
      end
    end
  end

  // Request capture, array and parity state carry no reset
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdat_q  <= wdat_d;
    rd_op_q <= rd_op_d;
    wr_op_q <= wr_op_d;
    err_q   <= err_d;
    if (!rst && state_q == S_ACCESS && wr_op_q && !err_q) mem[addr_q] <= wdat_q;
  end

`ifdef DATA_MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && state_q == S_ACCESS && wr_op_q && !err_q) par_mem[addr_q] <= ^wdat_q;
    if (state_q == S_ACCESS)
      perr_q <= rd_op_q && !err_q && ((^mem[addr_q]) != par_mem[addr_q]);
  end
`else
  assign perr_q = 1'b0;
`endif

  assign mem_ready = (state_q == S_RESP);
  assign data_oe   = (state_q == S_RESP) && rd_op_q && !err_q;
  assign bus_err   = (state_q == S_RESP) && (err_q || perr_q);
  assign busy      = (state_q != S_IDLE);
  assign rd_data   = rd_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: instance 0 uses two wait states, instance 1 uses none.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] addr_s [2];
  logic [18:0] wdat_s [2];
  logic [18:0] rdat_s [2];
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic        oe_s   [2];
  logic        rdy_s  [2];
  logic        err_s  [2];
  logic        busy_s [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl #(.DATA_W(19), .ADDR_W(19), .DEPTH(256), .WAIT_STATES(2)) dut0 (
    .clk(clk), .rst(rst), .address(addr_s[0]), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
    .wr_data(wdat_s[0]), .rd_data(rdat_s[0]), .data_oe(oe_s[0]), .mem_ready(rdy_s[0]),
    .bus_err(err_s[0]), .busy(busy_s[0]));

  data_mem_ctrl #(.DATA_W(19), .ADDR_W(19), .DEPTH(256), .WAIT_STATES(0)) dut1 (
    .clk(clk), .rst(rst), .address(addr_s[1]), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
    .wr_data(wdat_s[1]), .rd_data(rdat_s[1]), .data_oe(oe_s[1]), .mem_ready(rdy_s[1]),
    .bus_err(err_s[1]), .busy(busy_s[1]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else             n_pass++;
  endtask

  // Called at a negedge; returns at the negedge of the RESP cycle with the request dropped.
  task automatic xfer(input int s, input logic rd, input logic wr, input logic [18:0] a,
                      input logic [18:0] d, output int lat, output int rcyc,
                      output logic [18:0] rdat, output logic oe, output logic err);
    bit found = 1'b0;
    int guard = 0;
    rd_s[s] = rd; wr_s[s] = wr; addr_s[s] = a; wdat_s[s] = d;
    while (busy_s[s] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rdy_s[s]) found = 1'b1;
    end
    if (!found) chk("ready_timeout", 0, 1);
    rdat = rdat_s[s]; oe = oe_s[s]; err = err_s[s]; rcyc = cyc;
    rd_s[s] = 1'b0; wr_s[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    int guard = 0;
    while (busy_s[s] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
  endtask

  int          lat, rc;
  int          rcs [4];
  logic [18:0] rdat;
  logic        oe, err;
  int          rdy_seen;
  bit          got;

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr_s[i] = '0; wdat_s[i] = '0; rd_s[i] = 1'b0; wr_s[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs0", {rdat_s[0], oe_s[0], rdy_s[0], err_s[0], busy_s[0]}, 0);
    chk("rst_outputs1", {rdat_s[1], oe_s[1], rdy_s[1], err_s[1], busy_s[1]}, 0);

    // Two wait states: write then read back
    xfer(0, 0, 1, 19'd5, 19'd99, lat, rc, rdat, oe, err);
    chk("ws2_wr_lat", lat, 3);
    chk("ws2_wr_oe_err", {oe, err}, 0);
    xfer(0, 1, 0, 19'd5, 19'd0, lat, rc, rdat, oe, err);
    chk("ws2_rd_lat", lat, 3);
    chk("ws2_rd_data", rdat, 99);
    chk("ws2_rd_oe_err", {oe, err}, 2'b10);

    // Zero wait states, back-to-back at boundary addresses
    xfer(1, 0, 1, 19'd0, 19'h7FFFF, lat, rcs[0], rdat, oe, err);
    chk("ws0_lat", lat, 1);
    xfer(1, 0, 1, 19'd255, 19'd42, lat, rcs[1], rdat, oe, err);
    xfer(1, 1, 0, 19'd255, 19'd0, lat, rcs[2], rdat, oe, err);
    chk("ws0_rd255", rdat, 42);
    chk("ws0_rd255_oe", {oe, err}, 2'b10);
    xfer(1, 1, 0, 19'd0, 19'd0, lat, rcs[3], rdat, oe, err);
    chk("ws0_rd0", rdat, 19'h7FFFF);
    chk("ws0_rd0_lat", lat, 1);
    chk("ws0_space01", rcs[1] - rcs[0], 3);
    chk("ws0_space23", rcs[3] - rcs[2], 3);

    // Error classes: out-of-range read, simultaneous read+write
    xfer(0, 0, 1, 19'd3, 19'd55, lat, rc, rdat, oe, err);
    xfer(0, 1, 0, 19'd256, 19'd0, lat, rc, rdat, oe, err);
    chk("oor_resp", {rdat, oe, err}, {19'd0, 2'b01});
    chk("oor_lat", lat, 3);
    xfer(0, 1, 1, 19'd3, 19'd999, lat, rc, rdat, oe, err);
    chk("rw_resp", {rdat, oe, err}, {19'd0, 2'b01});
    xfer(0, 1, 0, 19'd3, 19'd0, lat, rc, rdat, oe, err);
    chk("addr3_kept", rdat, 55);

    // Address/data changes and a read pulse during WAIT are ignored
    xfer(0, 0, 1, 19'd7, 19'd321, lat, rc, rdat, oe, err);
    @(negedge clk);
    wait_idle(0);
    wr_s[0] = 1'b1; addr_s[0] = 19'd4; wdat_s[0] = 19'd11;
    @(posedge clk);
    @(negedge clk);
    chk("busy_in_wait", busy_s[0], 1);
    addr_s[0] = 19'd7; wdat_s[0] = 19'd123; rd_s[0] = 1'b1;
    @(negedge clk);
    rd_s[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rdy_s[0]) got = 1'b1;
      else @(negedge clk);
    end
    chk("late_chg_ready", got, 1);
    chk("late_chg_err", err_s[0], 0);
    wr_s[0] = 1'b0;
    xfer(0, 1, 0, 19'd4, 19'd0, lat, rc, rdat, oe, err);
    chk("addr4_val", rdat, 11);
    xfer(0, 1, 0, 19'd7, 19'd0, lat, rc, rdat, oe, err);
    chk("addr7_kept", rdat, 321);

    // Reset during WAIT drops the write
    xfer(0, 0, 1, 19'd9, 19'd500, lat, rc, rdat, oe, err);
    @(negedge clk);
    wait_idle(0);
    wr_s[0] = 1'b1; addr_s[0] = 19'd9; wdat_s[0] = 19'd77;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr_s[0] = 1'b0;
    chk("rst_busy", busy_s[0], 0);
    rdy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rdy_s[0]) rdy_seen++;
      @(negedge clk);
    end
    chk("rst_no_ready", rdy_seen, 0);
    xfer(0, 1, 0, 19'd9, 19'd0, lat, rc, rdat, oe, err);
    chk("addr9_kept", rdat, 500);
    chk("post_rst_lat", lat, 3);

`ifdef DATA_MEM_PARITY_EN
    xfer(0, 0, 1, 19'd2, 19'd6, lat, rc, rdat, oe, err);
    @(negedge clk);
    dut0.mem[2] = dut0.mem[2] ^ 19'd1;
    xfer(0, 1, 0, 19'd2, 19'd0, lat, rc, rdat, oe, err);
    chk("par_data", rdat, 7);
    chk("par_oe_err", {oe, err}, 2'b11);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
